// File: rtl/reg_display_scanner.sv
// rtl/reg_display_scanner.sv - register-bank read scanner multiplexed onto a 4-digit common-anode 7-segment display
// Optional feature macro DP_MARK_EN adds an active-low dp output lit on the address digits.
module reg_display_scanner #(
   parameter int BIT_ADDR    = 3,
   parameter int BIT_DATO    = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int SCAN_FRAMES = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic [BIT_ADDR-1:0] sw_addrA,
   input  logic [BIT_ADDR-1:0] sw_addrB,
   output logic [BIT_ADDR-1:0] addrRa,
   output logic [BIT_ADDR-1:0] addrRb,
   input  logic [BIT_DATO-1:0] datOutRa,
   input  logic [BIT_DATO-1:0] datOutRb,
   output logic [3:0]          an,
   output logic [6:0]          seg
`ifdef DP_MARK_EN
   ,
   output logic                dp
`endif
);

   localparam int RW = $clog2(REFRESH_DIV + 1);
   localparam int FW = $clog2(SCAN_FRAMES + 1);
   localparam logic [RW-1:0]       REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [RW-1:0]       REF_ONE    = RW'(1);
   localparam logic [FW-1:0]       FRAME_LAST = FW'(SCAN_FRAMES - 1);
   localparam logic [FW-1:0]       FRAME_ONE  = FW'(1);
   localparam logic [BIT_ADDR-1:0] ADDR_ONE   = BIT_ADDR'(1);

   logic [RW-1:0]       refreshCnt;
   logic [FW-1:0]       frameCnt;
   logic [1:0]          digitIdx;
   logic [BIT_ADDR-1:0] scanPtr;
   logic [BIT_DATO-1:0] capA, capB;
   logic                modeQ;
   logic                tick, frameEnd, modeChg, scanStep;
   logic [3:0]          nibble;

   assign tick     = (refreshCnt == REF_LAST);
   assign frameEnd = tick && (digitIdx == 2'd3);
   assign modeChg  = (mode != modeQ);
   // A mode change restarts the frame count, so it also suppresses a step on that edge.
   assign scanStep = frameEnd && (frameCnt == FRAME_LAST) && mode && !modeChg;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      nibble = 4'h0;
      case (digitIdx)
         2'd0: nibble = 4'(capB);
         2'd1: nibble = 4'(addrRb);
         2'd2: nibble = 4'(capA);
         default: nibble = 4'(addrRa);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refreshCnt <= '0;
         digitIdx   <= 2'd0;
         frameCnt   <= '0;
         scanPtr    <= '0;
         addrRa     <= '0;
         addrRb     <= '0;
         capA       <= '0;
         capB       <= '0;
         modeQ      <= mode;
         an         <= 4'b1111;
         seg        <= 7'b1111111;
`ifdef DP_MARK_EN
         dp         <= 1'b1;
`endif
      end else begin
         modeQ      <= mode;
         refreshCnt <= tick ? '0 : refreshCnt + REF_ONE;
         if (tick)
            digitIdx <= digitIdx + 2'd1;
         if (modeChg)
            frameCnt <= '0;
         else if (frameEnd)
            frameCnt <= (frameCnt == FRAME_LAST) ? '0 : frameCnt + FRAME_ONE;
         if (scanStep)
            scanPtr <= scanPtr + ADDR_ONE;
         if (mode) begin
            addrRa <= scanPtr;
            addrRb <= scanPtr + ADDR_ONE;
         end else begin
            addrRa <= sw_addrA;
            addrRb <= sw_addrB;
         end
         capA <= datOutRa;
         capB <= datOutRb;
         an   <= ~(4'b0001 << digitIdx);
         seg  <= hex7(nibble);
`ifdef DP_MARK_EN
         dp   <= ~digitIdx[0];
`endif
      end
   end

endmodule

// File: tb/tb_reg_display_scanner.sv
// tb/tb_reg_display_scanner.sv - scoreboard bench for reg_display_scanner with a stub bank (data = addr ^ 4'hA)
module tb_reg_display_scanner;

   logic       clk = 1'b0;
   logic       rst, mode;
   logic [2:0] swA, swB, addrRa, addrRb;
   logic [3:0] datA, datB, an;
   logic [6:0] seg;
`ifdef DP_MARK_EN
   logic       dp;
`endif

   int passCnt = 0;
   int checkCnt = 0;
   int n = 0;

   typedef struct {
      int         kind;
      string      tag;
      logic [7:0] exp;
   } sb_t;
   sb_t sbq[$];

   always #5 clk = ~clk;

   assign datA = 4'(addrRa) ^ 4'hA;
   assign datB = 4'(addrRb) ^ 4'hA;

   reg_display_scanner #(
      .BIT_ADDR(3), .BIT_DATO(4), .REFRESH_DIV(4), .SCAN_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .sw_addrA(swA), .sw_addrB(swB),
      .addrRa(addrRa), .addrRb(addrRb),
      .datOutRa(datA), .datOutRb(datB),
      .an(an), .seg(seg)
`ifdef DP_MARK_EN
      , .dp(dp)
`endif
   );

   function automatic logic [6:0] segOf(input logic [3:0] v);
      logic [6:0] tbl [16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[v];
   endfunction

   function automatic int digitOf(input int nn);
      return ((nn - 1) / 4) % 4;
   endfunction

   function automatic logic [7:0] observe(input int kind);
      case (kind)
         0: return {4'h0, an};
         1: return {1'b0, seg};
         2: return {5'h0, addrRa};
         3: return {5'h0, addrRb};
`ifdef DP_MARK_EN
         4: return {7'h0, dp};
`endif
         default: return 8'hFF;
      endcase
   endfunction

   task automatic push(input int kind, input string tag, input logic [7:0] e);
      sb_t s;
      s.kind = kind; s.tag = tag; s.exp = e;
      sbq.push_back(s);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) n = 0; else n++;
      #1;
   endtask

   task automatic drain();
      sb_t s;
      logic [7:0] o;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         o = observe(s.kind);
         checkCnt++;
         assert (o === s.exp) passCnt++;
         else $error("FAIL %s n=%0d observed=%h expected=%h", s.tag, n, o, s.exp);
      end
   endtask

   // Expected an (and dp) for the edge about to happen.
   task automatic pushDisplay();
      int nn;
      logic [3:0] e;
      nn = rst ? 0 : n + 1;
      e = (nn == 0) ? 4'b1111 : ~(4'b0001 << digitOf(nn));
      push(0, "an", {4'h0, e});
`ifdef DP_MARK_EN
      push(4, "dp", (nn == 0) ? 8'd1 : ((digitOf(nn) % 2 == 1) ? 8'd0 : 8'd1));
`endif
   endtask

   task automatic resetPhase(input int cycles, input logic m);
      rst = 1'b1; mode = m;
      repeat (cycles) begin
         pushDisplay();
         push(1, "segRst", 8'h7F);
         push(2, "addrRaRst", 8'd0);
         push(3, "addrRbRst", 8'd0);
         step();
         drain();
      end
      rst = 1'b0;
   endtask

   task automatic manualPattern(input logic [2:0] a, input logic [2:0] b);
      int nn;
      logic [3:0] v;
      swA = a; swB = b;
      pushDisplay();
      push(2, "addrRaMan", {5'h0, a});
      push(3, "addrRbMan", {5'h0, b});
      step(); drain();
      repeat (2) begin pushDisplay(); step(); drain(); end
      repeat (16) begin
         nn = n + 1;
         case (digitOf(nn))
            3: v = 4'(a);
            2: v = 4'(a) ^ 4'hA;
            1: v = 4'(b);
            default: v = 4'(b) ^ 4'hA;
         endcase
         pushDisplay();
         push(1, "segMan", {1'b0, segOf(v)});
         step(); drain();
      end
   endtask

   // Auto addresses: ptr = base + one step per 32 cycles counted from edge baseN.
   task automatic autoRun(input int upto, input int base, input int baseN);
      int nn, p;
      while (n < upto) begin
         nn = n + 1;
         p = (base + (nn - baseN) / 32) % 8;
         pushDisplay();
         push(2, "addrRaAuto", 8'(p));
         push(3, "addrRbAuto", 8'((p + 1) % 8));
         step(); drain();
      end
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; swA = 3'd0; swB = 3'd0;

      // Reset, then digit walk in manual mode.
      resetPhase(3, 1'b0);
      repeat (24) begin pushDisplay(); step(); drain(); end

      // Manual display content.
      manualPattern(3'd3, 3'd5);
      manualPattern(3'd7, 3'd0);

      // Auto scan from reset, including the 7/0 -> 0/1 wrap.
      resetPhase(3, 1'b1);
      autoRun(300, 0, 1);

      // Manual excursion while scan_ptr=4; resume lands on a frame boundary.
      resetPhase(2, 1'b1);
      autoRun(140, 0, 1);
      mode = 1'b0; swA = 3'd6; swB = 3'd2;
      repeat (20) begin
         pushDisplay();
         push(2, "addrRaExc", 8'd6);
         push(3, "addrRbExc", 8'd2);
         step(); drain();
      end
      mode = 1'b1;
      autoRun(226, 4, 161);

      // Reset mid-digit (refresh_cnt=2, step 6), then identical restart.
      resetPhase(1, 1'b1);
      autoRun(40, 0, 1);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
